// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: built-in self-test sequencer for a small combinational gate network
//
// Walks every input vector of the gate under test in ascending order, waits SETTLE
// cycles, samples the gate output and compares it with TRUTH[vector].
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   start                begin a run (only sampled while idle)
//   dut_in / dut_out     vector driven to the gate, gate output sampled back
//   busy, done           run in progress, one-cycle completion pulse
//   pass                 last run had zero mismatches
//   err_count            number of mismatching vectors in the last run
//   fail_valid, fail_vec first mismatching vector and its valid flag
// Build option: define GATE_BIST_HALT_EN to stop the run at the first mismatch.
module gate_bist_ctrl #(
    parameter int                  N_IN   = 2,
    parameter int                  SETTLE = 1,
    parameter logic [2**N_IN-1:0]  TRUTH  = 4'b0111
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_vec
);
    typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;
    state_t state, state_nx;
    logic [N_IN-1:0] vec;
    logic [3:0] settle;
    logic mis, last, halt;
    // case inequality so that an X/Z gate output is reported as a failure
    assign mis  = dut_out !== TRUTH[vec];
    assign last = &vec;
`ifdef GATE_BIST_HALT_EN
    assign halt = mis;
`else
    assign halt = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? APPLY : IDLE;
            APPLY:   state_nx = (SETTLE == 0) ? CHECK : WAIT;
            WAIT:    state_nx = (settle <= 4'd1) ? CHECK : WAIT;
            CHECK:   state_nx = (last || halt) ? DONE : APPLY;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // outputs are registered, so each one appears one edge after the state that sets it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            settle     <= '0;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    vec        <= '0;
                    err_count  <= '0;
                    fail_valid <= 1'b0;
                    fail_vec   <= '0;
                    pass       <= 1'b0;
                end
                APPLY: begin
                    dut_in <= vec;
                    busy   <= 1'b1;
                    settle <= 4'(SETTLE);
                end
                WAIT: settle <= settle - 4'd1;
                CHECK: begin
                    if (mis) begin
                        err_count <= err_count + 1'b1;
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_vec   <= vec;
                        end
                    end
                    if (!last && !halt) vec <= vec + 1'b1;
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= (err_count == '0);
                end
                default: ;
            endcase
        end
    end
endmodule
